counter_mod_n: RTL and testbench

Parametrised modulo-N up/down counter with synchronous load, count enable, prescaler, terminal-count pulse and sticky wrap flag. Successor to the fixed-width free-running counter: the same single-clock, clear-to-zero counting core, generalised in width, modulus, direction and rate. It is used as a timebase and event counter wherever the design needs a non-power-of-two period or a reload value.

---
 rtl/counter_mod_n.sv | 140 ++++++++++++++
 tb/tb_counter_mod_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with synchronous load, count enable, prescaler,
// terminal-count pulse and sticky wrap flag. Define COUNTER_MODN_SATURATE_EN to hold at the bounds instead of wrapping.
module counter_mod_n #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd256,
    parameter int              PRESCALE = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_flag
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1'b1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ZERO  = {PS_W{1'b0}};
    localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1'b1);

    // Out-of-range reload values land on the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if (64'(value) >= MODULUS) begin
            result = TOP_VAL;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             wrap_flag_r;
    logic [PS_W-1:0]  ps_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_nxt_s;
    logic             wrap_flag_nxt_s;
    logic [PS_W-1:0]  ps_nxt_s;
    logic             step_s;
    logic             at_top_s;
    logic             at_bottom_s;

    assign at_top_s    = (count_r == TOP_VAL);
    assign at_bottom_s = (count_r == ZERO_VAL);

    // Prescaler: advances on enabled cycles, strobes a step when it rolls over.
    always_comb begin
        ps_nxt_s = ps_r;
        step_s   = 1'b0;
        if (load) begin
            ps_nxt_s = PS_ZERO;
        end else if (enable) begin
            if (ps_r == PS_LAST) begin
                ps_nxt_s = PS_ZERO;
                step_s   = 1'b1;
            end else begin
                ps_nxt_s = ps_r + PS_ONE;
            end
        end else begin
            ps_nxt_s = ps_r;
        end
    end

    // Count next-state: load beats step, step beats hold; tc marks a wrap.
    always_comb begin
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        if (load) begin
            count_nxt_s = clamp_load(load_value);
        end else if (step_s) begin
            if (up_down) begin
                if (at_top_s) begin
                    tc_nxt_s = 1'b1;
`ifdef COUNTER_MODN_SATURATE_EN
                    count_nxt_s = count_r;
`else
                    count_nxt_s = ZERO_VAL;
`endif
                end else begin
                    count_nxt_s = count_r + ONE_VAL;
                end
            end else begin
                if (at_bottom_s) begin
                    tc_nxt_s = 1'b1;
`ifdef COUNTER_MODN_SATURATE_EN
                    count_nxt_s = count_r;
`else
                    count_nxt_s = TOP_VAL;
`endif
                end else begin
                    count_nxt_s = count_r - ONE_VAL;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Sticky flag: a wrap in the same cycle outranks flag_clr.
    always_comb begin
        wrap_flag_nxt_s = wrap_flag_r;
        if (tc_nxt_s) begin
            wrap_flag_nxt_s = 1'b1;
        end else if (flag_clr) begin
            wrap_flag_nxt_s = 1'b0;
        end else begin
            wrap_flag_nxt_s = wrap_flag_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_r     <= ZERO_VAL;
            tc_r        <= 1'b0;
            wrap_flag_r <= 1'b0;
            ps_r        <= PS_ZERO;
        end else begin
            count_r     <= count_nxt_s;
            tc_r        <= tc_nxt_s;
            wrap_flag_r <= wrap_flag_nxt_s;
            ps_r        <= ps_nxt_s;
        end
    end

    assign count     = count_r;
    assign tc        = tc_r;
    assign wrap_flag = wrap_flag_r;

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: MODULUS=10 instance at PRESCALE=1 and PRESCALE=3.
module tb_counter_mod_n;

    typedef struct {
        logic       ld;
        logic       en;
        logic       ud;
        logic [7:0] lv;
        logic       fc;
        logic [7:0] ec;
        logic       etc;
        logic       ef;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear;
    logic       enable_a, up_down_a, load_a, flag_clr_a;
    logic [7:0] load_value_a;
    logic [7:0] count_a;
    logic       tc_a, wrap_flag_a;
    logic       enable_b, up_down_b, load_b, flag_clr_b;
    logic [7:0] load_value_b;
    logic [7:0] count_b;
    logic       tc_b, wrap_flag_b;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    counter_mod_n #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clock(clock), .clear(clear), .enable(enable_a), .up_down(up_down_a),
        .load(load_a), .load_value(load_value_a), .flag_clr(flag_clr_a),
        .count(count_a), .tc(tc_a), .wrap_flag(wrap_flag_a)
    );

    counter_mod_n #(.WIDTH(8), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clock(clock), .clear(clear), .enable(enable_b), .up_down(up_down_b),
        .load(load_b), .load_value(load_value_b), .flag_clr(flag_clr_b),
        .count(count_b), .tc(tc_b), .wrap_flag(wrap_flag_b)
    );

    function automatic vec_t mk(input logic ld, input logic en, input logic ud,
                                input logic [7:0] lv, input logic fc,
                                input logic [7:0] ec, input logic etc, input logic ef);
        vec_t v;
        v.ld = ld; v.en = en; v.ud = ud; v.lv = lv; v.fc = fc;
        v.ec = ec; v.etc = etc; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic ld, input logic en, input logic ud,
                           input logic [7:0] lv, input logic fc);
        load_a = ld; enable_a = en; up_down_a = ud; load_value_a = lv; flag_clr_a = fc;
    endtask

    task automatic drive_b(input logic ld, input logic en, input logic ud, input logic [7:0] lv);
        load_b = ld; enable_b = en; up_down_b = ud; load_value_b = lv; flag_clr_b = 1'b0;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_b(input string name, input logic [7:0] ec, input logic etc, input logic ef);
        check({name, " count_b"}, 32'(count_b), 32'(ec));
        check({name, " tc_b"}, 32'(tc_b), 32'(etc));
        check({name, " wrap_flag_b"}, 32'(wrap_flag_b), 32'(ef));
    endtask

    initial begin
        logic [7:0] pre_cnt [11];
        logic       pre_en  [11];

        clear = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        drive_b(1'b0, 1'b0, 1'b1, 8'd0);

`ifdef COUNTER_MODN_SATURATE_EN
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'd8, 1'b0, 8'd8, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd9, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd9, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd9, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd8, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1));
`else
        for (int i = 1; i <= 9; i++) begin
            vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'(i), 1'b0, 1'b0));
        end
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1));
        // down wrap from a loaded 2
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 8'd2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd9, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd8, 1'b0, 1'b1));
        // load priority and clamping at the range boundary
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'd15, 1'b0, 8'd9, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd6, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd6, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'd9, 1'b0, 8'd9, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 8'd9, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1));
        // flag clear alone, then coincident with a wrap
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'd9, 1'b0, 8'd9, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0));
        // direction changes between steps
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd9, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 8'd3, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd4, 1'b0, 1'b1));
`endif

        #12;
        check("reset count", 32'(count_a), 32'd0);
        check("reset tc", 32'(tc_a), 32'd0);
        check("reset wrap_flag", 32'(wrap_flag_a), 32'd0);
        check_b("reset", 8'd0, 1'b0, 1'b0);
        tick;
        clear = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].lv, vecs[i].fc);
            tick;
            check($sformatf("row%0d count", i), 32'(count_a), 32'(vecs[i].ec));
            check($sformatf("row%0d tc", i), 32'(tc_a), 32'(vecs[i].etc));
            check($sformatf("row%0d wrap_flag", i), 32'(wrap_flag_a), 32'(vecs[i].ef));
        end

        // asynchronous clear in the middle of a clock period at count 7
        drive_a(1'b1, 1'b0, 1'b1, 8'd7, 1'b0);
        tick;
        check("preclear count", 32'(count_a), 32'd7);
        drive_a(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        #2;
        clear = 1'b1;
        #1;
        check("async clear count", 32'(count_a), 32'd0);
        check("async clear wrap_flag", 32'(wrap_flag_a), 32'd0);
        tick;
        check("held clear count", 32'(count_a), 32'd0);
        clear = 1'b0;
        tick;
        check("post clear step", 32'(count_a), 32'd1);
        drive_a(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);

        // prescaler of 3 with a two-cycle enable gap
        pre_en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pre_cnt = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
        for (int i = 0; i < 11; i++) begin
            drive_b(1'b0, pre_en[i], 1'b1, 8'd0);
            tick;
            check_b($sformatf("pre%0d", i), pre_cnt[i], 1'b0, 1'b0);
        end

        // a load mid-prescale restarts the prescaler
        drive_b(1'b0, 1'b1, 1'b1, 8'd0);
        tick;
        check_b("pre partial", 8'd3, 1'b0, 1'b0);
        drive_b(1'b1, 1'b1, 1'b1, 8'd9);
        tick;
        check_b("pre load", 8'd9, 1'b0, 1'b0);
        drive_b(1'b0, 1'b1, 1'b1, 8'd0);
        tick;
        check_b("pre after load 1", 8'd9, 1'b0, 1'b0);
        tick;
        check_b("pre after load 2", 8'd9, 1'b0, 1'b0);
        tick;
`ifdef COUNTER_MODN_SATURATE_EN
        check_b("pre after load 3", 8'd9, 1'b1, 1'b1);
`else
        check_b("pre after load 3", 8'd0, 1'b1, 1'b1);
`endif
        drive_b(1'b0, 1'b0, 1'b1, 8'd0);
        tick;
        check("pre tc single", 32'(tc_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
